// File: rtl/lag_counter.sv
// rtl/lag_counter.sv - photodiode lag counter: trigger-to-bright-edge delay in microseconds
module lag_counter #(
   parameter int          PRESCALE   = 27,
   parameter int          DEBOUNCE   = 16,
   parameter logic [19:0] TIMEOUT_US = 20'd999_999
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        starttrigger,
   input  logic        sensor,
   output logic [19:0] lag_us,
   output logic        lag_valid,
   output logic        timeout,
   output logic        busy,
   output logic [7:0]  measure_count
);

   typedef enum logic {
      IDLE    = 1'b0,
      MEASURE = 1'b1
   } state_t;

   localparam logic [9:0] PRESC_LAST = 10'(PRESCALE - 1);
   localparam logic [7:0] DB_LAST    = 8'(DEBOUNCE - 1);

   state_t      state;
   state_t      state_next;

   logic        sync1;
   logic        sync2;
   logic        sensor_db;
   logic        sensor_db_prev;
   logic [7:0]  db_cnt;

   logic [9:0]  presc;
   logic [19:0] us_cnt;

   logic        rise;
   logic        capture;
   logic        abort;
   logic        clear_cnt;

   // Bright edge of the debounced sensor, one edge after sensor_db goes high.
   assign rise = sensor_db & ~sensor_db_prev;
   assign busy = (state == MEASURE);

   // State register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state and control strobes; a capture wins over both retrigger and timeout.
   always_comb begin
      state_next = state;
      capture    = 1'b0;
      abort      = 1'b0;
      clear_cnt  = 1'b0;
      case (state)
         IDLE: begin
            if (starttrigger) begin
               state_next = MEASURE;
               clear_cnt  = 1'b1;
            end
         end
         MEASURE: begin
            if (rise) begin
               capture = 1'b1;
               if (starttrigger) begin
                  clear_cnt = 1'b1;
               end else begin
                  state_next = IDLE;
               end
            end else if (starttrigger) begin
               clear_cnt = 1'b1;
            end else if (us_cnt == TIMEOUT_US) begin
               abort      = 1'b1;
               state_next = IDLE;
            end
         end
      endcase
   end

   // Two-flop synchronizer followed by a stability-count debouncer.
   always_ff @(posedge clock) begin
      if (reset) begin
         sync1          <= 1'b0;
         sync2          <= 1'b0;
         sensor_db      <= 1'b0;
         sensor_db_prev <= 1'b0;
         db_cnt         <= 8'd0;
      end else begin
         sync1          <= sensor;
         sync2          <= sync1;
         sensor_db_prev <= sensor_db;
         if (sync2 != sensor_db) begin
            if (db_cnt == DB_LAST) begin
               sensor_db <= sync2;
               db_cnt    <= 8'd0;
            end else begin
               db_cnt <= db_cnt + 8'd1;
            end
         end else begin
            db_cnt <= 8'd0;
         end
      end
   end

   // Microsecond timebase; frozen on the edge that leaves MEASURE so us_cnt never passes the limit.
   always_ff @(posedge clock) begin
      if (reset) begin
         presc  <= 10'd0;
         us_cnt <= 20'd0;
      end else if (clear_cnt) begin
         presc  <= 10'd0;
         us_cnt <= 20'd0;
      end else if (state == MEASURE && state_next == MEASURE) begin
         if (presc == PRESC_LAST) begin
            presc  <= 10'd0;
            us_cnt <= us_cnt + 20'd1;
         end else begin
            presc <= presc + 10'd1;
         end
      end
   end

   // Result registers and single-cycle event pulses.
   always_ff @(posedge clock) begin
      if (reset) begin
         lag_us        <= 20'd0;
         lag_valid     <= 1'b0;
         timeout       <= 1'b0;
         measure_count <= 8'd0;
      end else begin
         lag_valid <= capture;
         timeout   <= abort;
         if (capture) begin
            lag_us        <= us_cnt;
            measure_count <= measure_count + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_lag_counter.sv
// tb/tb_lag_counter.sv - randomized and directed check of lag_counter against a window-based model
module tb_lag_counter;

   localparam int          PR = 4;
   localparam int          DB = 2;
   localparam logic [19:0] TO = 20'd100;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        starttrigger = 1'b0;
   logic        sensor = 1'b0;
   logic [19:0] lag_us;
   logic        lag_valid;
   logic        timeout;
   logic        busy;
   logic [7:0]  measure_count;

   int n_vec  = 0;
   int n_miss = 0;
   int n_valid_seen = 0;
   int n_to_seen    = 0;

   // model state
   int          edge_n = 0;
   int          t0 = 0;
   bit          act = 1'b0;
   logic        db_q = 1'b0;
   logic        db_qq = 1'b0;
   logic        hist[$];
   logic [19:0] m_lag = 20'd0;
   logic [7:0]  m_cnt = 8'd0;
   logic        m_valid = 1'b0;
   logic        m_to = 1'b0;

   lag_counter #(.PRESCALE(PR), .DEBOUNCE(DB), .TIMEOUT_US(TO)) dut (
      .clock        (clock),
      .reset        (reset),
      .starttrigger (starttrigger),
      .sensor       (sensor),
      .lag_us       (lag_us),
      .lag_valid    (lag_valid),
      .timeout      (timeout),
      .busy         (busy),
      .measure_count(measure_count)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Reference: the debounced level flips once the last DB synchronized samples all
   // disagree with it; the lag is floor((k-1)/PR) edges after the trigger edge.
   task automatic model(input logic r, input logic tr, input logic s);
      bit rise;
      bit stable;
      int us_pre;
      if (r) begin
         act = 1'b0; m_lag = '0; m_cnt = '0; m_valid = 1'b0; m_to = 1'b0;
         db_q = 1'b0; db_qq = 1'b0; edge_n = 0;
         hist.delete();
         for (int i = 0; i < DB + 2; i++) hist.push_back(1'b0);
      end else begin
         edge_n++;
         rise = db_q && !db_qq;
         m_valid = 1'b0;
         m_to = 1'b0;
         if (act) begin
            us_pre = (edge_n - t0 - 1) / PR;
            if (rise) begin
               m_lag = 20'(us_pre);
               m_valid = 1'b1;
               m_cnt = m_cnt + 8'd1;
               if (tr) t0 = edge_n;
               else act = 1'b0;
            end else if (tr) begin
               t0 = edge_n;
            end else if (us_pre == int'(TO)) begin
               m_to = 1'b1;
               act = 1'b0;
            end
         end else if (tr) begin
            act = 1'b1;
            t0 = edge_n;
         end
         stable = 1'b1;
         for (int k = 1; k <= DB; k++)
            if (hist[hist.size() - 1 - k] == db_q) stable = 1'b0;
         db_qq = db_q;
         if (stable) db_q = !db_q;
         hist.push_back(s);
         void'(hist.pop_front());
      end
   endtask

   task automatic step(input logic r, input logic tr, input logic s);
      reset = r;
      starttrigger = tr;
      sensor = s;
      @(posedge clock);
      model(r, tr, s);
      #1;
      if (lag_valid) n_valid_seen++;
      if (timeout) n_to_seen++;
      check("cyc", 64'({lag_us, measure_count, lag_valid, timeout, busy}),
            64'({m_lag, m_cnt, m_valid, m_to, act}));
   endtask

   initial begin
      int v0;
      int t_0;
      int hold;
      logic rs;

      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
      check("rst_outputs", 64'({lag_us, measure_count, lag_valid, timeout, busy}), 64'd0);

      v0 = n_valid_seen; t_0 = n_to_seen;
      for (int i = 0; i < 50; i++) step(1'b0, 1'b0, 1'b0);
      check("idle_pulses", 64'(n_valid_seen - v0 + n_to_seen - t_0), 64'd0);

      // stable rise at edge 40
      for (int r = 0; r < 60; r++) step(1'b0, r == 0, r >= 40);
      check("rise40_lag", 64'(lag_us), 64'd10);
      check("rise40_cnt", 64'(measure_count), 64'd1);
      check("rise40_busy", 64'(busy), 64'd0);

      // no activity -> timeout
      for (int r = 0; r < 20; r++) step(1'b0, 1'b0, 1'b0);
      t_0 = n_to_seen;
      for (int r = 0; r < 420; r++) step(1'b0, r == 0, 1'b0);
      check("to_pulses", 64'(n_to_seen - t_0), 64'd1);
      check("to_lag_kept", 64'(lag_us), 64'd10);
      check("to_busy", 64'(busy), 64'd0);

      // glitch at edge 20 ignored, stable rise at edge 60
      for (int r = 0; r < 80; r++) step(1'b0, r == 0, (r == 20) || (r >= 60));
      check("glitch_lag", 64'(lag_us), 64'd15);
      check("glitch_cnt", 64'(measure_count), 64'd2);

      // bright before trigger, fall at 10, rise at 30
      for (int r = 0; r < 20; r++) step(1'b0, 1'b0, 1'b1);
      for (int r = 0; r < 50; r++) step(1'b0, r == 0, !(r >= 10 && r < 30));
      check("prebright_lag", 64'(lag_us), 64'd8);

      // retrigger at 20, rise at 60
      for (int r = 0; r < 20; r++) step(1'b0, 1'b0, 1'b0);
      for (int r = 0; r < 80; r++) step(1'b0, (r == 0) || (r == 20), r >= 60);
      check("retrig_lag", 64'(lag_us), 64'd10);
      check("retrig_cnt", 64'(measure_count), 64'd4);

      // reset at edge 30 of MEASURE
      for (int r = 0; r < 20; r++) step(1'b0, 1'b0, 1'b0);
      v0 = n_valid_seen; t_0 = n_to_seen;
      for (int r = 0; r <= 30; r++) step(r == 30, r == 0, 1'b0);
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_cnt", 64'(measure_count), 64'd0);
      for (int r = 0; r < 30; r++) step(1'b0, 1'b0, r >= 5);
      check("midrst_pulses", 64'(n_valid_seen - v0 + n_to_seen - t_0), 64'd0);

      // rise and retrigger on the same edge (capture at 30), then fall/rise again
      for (int r = 0; r < 20; r++) step(1'b0, 1'b0, 1'b0);
      for (int r = 0; r < 80; r++) step(1'b0, (r == 0) || (r == 30), (r >= 26 && r < 40) || r >= 60);
      check("rise_trig_lag", 64'(lag_us), 64'd8);
      check("rise_trig_cnt", 64'(measure_count), 64'd2);

      // rise on the timeout edge: capture wins
      for (int r = 0; r < 20; r++) step(1'b0, 1'b0, 1'b0);
      t_0 = n_to_seen;
      for (int r = 0; r < 420; r++) step(1'b0, r == 0, r >= 397);
      check("rise_to_lag", 64'(lag_us), 64'd100);
      check("rise_to_nopulse", 64'(n_to_seen - t_0), 64'd0);

      // random traffic
      hold = 0;
      rs = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (hold == 0) begin
            rs = ~rs;
            hold = $urandom_range(1, 30);
         end else begin
            hold--;
         end
         step($urandom_range(0, 1499) == 0, $urandom_range(0, 59) == 0, rs);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
